// File: rtl/seq_divider_64by32.sv
// Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock under a start/busy/done handshake.
// Optional macro DIV_ERR_CHECK_EN enables divide-by-zero / overflow detection
// with a one-cycle fast path; without it the flags are held at 0.
module seq_divider_64by32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_zero,
  output logic                 overflow
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder (always < divisor once in CALC)
  logic [WIDTH-1:0]   lo_q, lo_d;         // low dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic               overflow_q, overflow_d;

  logic [WIDTH:0]     trial_c;
  logic [WIDTH-1:0]   diff_c;
  logic               take_c;
  logic [WIDTH-1:0]   rem_next_c;

  // One restoring step: shift in the next dividend bit and conditionally subtract.
  always_comb begin
    trial_c    = {rem_q, lo_q[WIDTH-1]};
    take_c     = (trial_c >= {1'b0, dvs_q});
    diff_c     = WIDTH'(trial_c - {1'b0, dvs_q});
    rem_next_c = take_c ? diff_c : trial_c[WIDTH-1:0];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    lo_d        = lo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvs_d      = divisor;
          rem_d      = dividend[DW-1:WIDTH];
          lo_d       = dividend[WIDTH-1:0];
          cnt_d      = '0;
          div_zero_d = 1'b0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_CALC;
`ifdef DIV_ERR_CHECK_EN
          if (divisor == '0 || dividend[DW-1:WIDTH] >= divisor) begin
            div_zero_d  = (divisor == '0);
            overflow_d  = (divisor != '0);
            quotient_d  = '1;
            remainder_d = dividend[WIDTH-1:0];
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rem_d = rem_next_c;
        lo_d  = {lo_q[WIDTH-2:0], take_c};
        cnt_d = CW'(cnt_q + 1'b1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          quotient_d  = {lo_q[WIDTH-2:0], take_c};
          remainder_d = rem_next_c;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      lo_q        <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      lo_q        <= lo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule
